// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the W stage / LL unit / decode and the regfile write-port arbiter.
// The arbiter connects through the slave modport. The environment connects through the master modport.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_p_valid_i;
  logic [4:0]      wb_p_addr_i;
  logic [XLEN-1:0] wb_p_data_i;
  logic            ll_valid_i;
  logic            ll_ready_o;
  logic [4:0]      ll_addr_i;
  logic [XLEN-1:0] ll_data_i;
  logic [4:0]      dec_rs1_addr_i;
  logic [4:0]      dec_rs2_addr_i;
  logic [4:0]      dec_rd_addr_i;
  logic            dec_rd_wren_i;
  logic            dec_ll_issue_i;
  logic            rd_wr_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic [1:0]      forward_decode_o;
  logic            stall_o;

  modport slave (
    input  wb_p_valid_i, wb_p_addr_i, wb_p_data_i,
    input  ll_valid_i, ll_addr_i, ll_data_i,
    input  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, dec_rd_wren_i, dec_ll_issue_i,
    output ll_ready_o, rd_wr_o, rd_addr_o, rd_data_o, forward_decode_o, stall_o
  );

  modport master (
    output wb_p_valid_i, wb_p_addr_i, wb_p_data_i,
    output ll_valid_i, ll_addr_i, ll_data_i,
    output dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, dec_rd_wren_i, dec_ll_issue_i,
    input  ll_ready_o, rd_wr_o, rd_addr_o, rd_data_o, forward_decode_o, stall_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: the pipeline W stage has priority. Long-latency results are buffered in a FIFO.
// A pending-destination scoreboard drives the decode stall, and the decode forwarding select is computed here.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_port_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [4:0]      fifo_addr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [31:0]      pend_q, pend_d;

  logic            ll_ready;
  logic            fifo_empty;
  logic            push, pop;
  logic            pipe_owns;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  logic            rd_wr;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            m1, m2, dual_fwd;
  logic [1:0]      fwd_sel;
  logic            raw1, raw2, waw, stall;
  logic            set_en;

  // Ready comes from the registered count only, so a full FIFO never accepts and pops in the same cycle
  assign ll_ready   = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = bus.ll_valid_i & ll_ready & (bus.ll_addr_i != 5'd0);
  assign pipe_owns  = bus.wb_p_valid_i & (bus.wb_p_addr_i != 5'd0);
  assign pop        = ~pipe_owns & ~fifo_empty;
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  always_comb begin
    rd_wr   = 1'b0;
    rd_addr = 5'd0;
    rd_data = '0;
    if (pipe_owns) begin
      rd_wr   = 1'b1;
      rd_addr = bus.wb_p_addr_i;
      rd_data = bus.wb_p_data_i;
    end else if (pop) begin
      rd_wr   = 1'b1;
      rd_addr = head_addr;
      rd_data = head_data;
    end
  end

  always_comb begin
    m1       = rd_wr & (bus.dec_rs1_addr_i == rd_addr) & (bus.dec_rs1_addr_i != 5'd0);
    m2       = rd_wr & (bus.dec_rs2_addr_i == rd_addr) & (bus.dec_rs2_addr_i != 5'd0);
    dual_fwd = m1 & m2;
    fwd_sel  = 2'b00;
    if (m1 && !m2)      fwd_sel = 2'b01;
    else if (m2 && !m1) fwd_sel = 2'b10;
  end

  // A pending register that is being popped this cycle is covered by forwarding, so it does not stall
  always_comb begin
    raw1  = (bus.dec_rs1_addr_i != 5'd0) & pend_q[bus.dec_rs1_addr_i]
            & ~(pop & (head_addr == bus.dec_rs1_addr_i));
    raw2  = (bus.dec_rs2_addr_i != 5'd0) & pend_q[bus.dec_rs2_addr_i]
            & ~(pop & (head_addr == bus.dec_rs2_addr_i));
    waw   = bus.dec_rd_wren_i & (bus.dec_rd_addr_i != 5'd0) & pend_q[bus.dec_rd_addr_i]
            & ~(pop & (head_addr == bus.dec_rd_addr_i));
    stall = raw1 | raw2 | waw | dual_fwd;
  end

  assign set_en = bus.dec_ll_issue_i & bus.dec_rd_wren_i & ~stall & (bus.dec_rd_addr_i != 5'd0);

  // Set is applied after clear so a same-cycle issue to the retiring register stays pending
  always_comb begin
    pend_d = pend_q;
    if (pop)    pend_d[head_addr] = 1'b0;
    if (set_en) pend_d[bus.dec_rd_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      pend_q <= pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.ll_addr_i;
      fifo_data_q[wr_ptr_q] <= bus.ll_data_i;
    end
  end

  assign bus.ll_ready_o       = ll_ready;
  assign bus.rd_wr_o          = rd_wr;
  assign bus.rd_addr_o        = rd_addr;
  assign bus.rd_data_o        = rd_data;
  assign bus.forward_decode_o = fwd_sel;
  assign bus.stall_o          = stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Each expected regfile write is queued by the stimulus.
// A negedge monitor pops and compares the queued write whenever rd_wr_o is high.
module tb_wb_port_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (bus.rd_wr_o === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=x%0d:%0h exp=none t=%0t",
                 bus.rd_addr_o, bus.rd_data_o, $time);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rd_addr_o, bus.rd_data_o} !== e) begin
          errors++;
          $display("FAIL write got=x%0d:%0h exp=x%0d:%0h t=%0t",
                   bus.rd_addr_o, bus.rd_data_o, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.wb_p_valid_i   = 1'b0; bus.wb_p_addr_i = '0; bus.wb_p_data_i = '0;
    bus.ll_valid_i     = 1'b0; bus.ll_addr_i   = '0; bus.ll_data_i   = '0;
    bus.dec_rs1_addr_i = '0;   bus.dec_rs2_addr_i = '0; bus.dec_rd_addr_i = '0;
    bus.dec_rd_wren_i  = 1'b0; bus.dec_ll_issue_i = 1'b0;
  endtask

  task automatic wbp(input logic [4:0] a, input logic [31:0] d);
    bus.wb_p_valid_i = 1'b1; bus.wb_p_addr_i = a; bus.wb_p_data_i = d;
  endtask

  task automatic ll(input logic [4:0] a, input logic [31:0] d);
    bus.ll_valid_i = 1'b1; bus.ll_addr_i = a; bus.ll_data_i = d;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic wren, input logic issue);
    bus.dec_rs1_addr_i = rs1; bus.dec_rs2_addr_i = rs2; bus.dec_rd_addr_i = rd;
    bus.dec_rd_wren_i = wren; bus.dec_ll_issue_i = issue;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    to_neg();
    chk("rst_rd_wr", bus.rd_wr_o, 0);
    chk("rst_rd_addr", bus.rd_addr_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_fwd", bus.forward_decode_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_ready", bus.ll_ready_o, 1);
    next();
    rst_ni = 1'b1;

    // write-port conflict: pipeline first, buffered LL result the cycle after
    ll(5'd7, 32'hAA);
    to_neg(); chk("cf_ready", bus.ll_ready_o, 1); chk("cf_nowrite", bus.rd_wr_o, 0);
    next(); idle(); wbp(5'd5, 32'h11); exp_wr(5'd5, 32'h11);
    to_neg(); chk("cf_n_addr", bus.rd_addr_o, 5);
    next(); idle(); exp_wr(5'd7, 32'hAA);
    to_neg(); chk("cf_n1_addr", bus.rd_addr_o, 7); chk("cf_n1_data", bus.rd_data_o, 32'hAA);
    next(); idle();
    to_neg(); chk("cf_idle", bus.rd_wr_o, 0);

    // RAW on an LL destination
    next(); dec(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    to_neg(); chk("raw_issue_stall", bus.stall_o, 0);
    next(); idle(); dec(5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    to_neg(); chk("raw_stall1", bus.stall_o, 1);
    next(); ll(5'd9, 32'h1234);
    to_neg(); chk("raw_stall2", bus.stall_o, 1);
    next(); bus.ll_valid_i = 1'b0; exp_wr(5'd9, 32'h1234);
    to_neg();
    chk("raw_pop_stall", bus.stall_o, 0);
    chk("raw_pop_fwd", bus.forward_decode_o, 2'b01);
    chk("raw_pop_data", bus.rd_data_o, 32'h1234);
    next(); idle(); dec(5'd9, 5'd0, 5'd11, 1'b1, 1'b0);
    to_neg(); chk("raw_cleared", bus.stall_o, 0); chk("raw_cleared_fwd", bus.forward_decode_o, 0);

    // WAW on an LL destination
    next(); idle(); dec(5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    to_neg(); chk("waw_issue", bus.stall_o, 0);
    next(); idle(); dec(5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
    to_neg(); chk("waw_stall", bus.stall_o, 1);
    next(); ll(5'd12, 32'hC0C0);
    to_neg(); chk("waw_stall2", bus.stall_o, 1);
    next(); bus.ll_valid_i = 1'b0; exp_wr(5'd12, 32'hC0C0);
    to_neg(); chk("waw_pop", bus.stall_o, 0);

    // FIFO full under continuous pipeline writes
    next(); idle(); wbp(5'd1, 32'h101); exp_wr(5'd1, 32'h101); ll(5'd20, 32'h200);
    to_neg(); chk("full_rdy0", bus.ll_ready_o, 1);
    next(); wbp(5'd2, 32'h102); exp_wr(5'd2, 32'h102); ll(5'd21, 32'h210);
    to_neg(); chk("full_rdy1", bus.ll_ready_o, 1);
    next(); wbp(5'd3, 32'h103); exp_wr(5'd3, 32'h103); ll(5'd22, 32'h220);
    to_neg(); chk("full_rdy2", bus.ll_ready_o, 0);
    next(); wbp(5'd4, 32'h104); exp_wr(5'd4, 32'h104);
    to_neg(); chk("full_rdy3", bus.ll_ready_o, 0);
    next(); bus.wb_p_valid_i = 1'b0; exp_wr(5'd20, 32'h200);
    to_neg(); chk("full_pop_rdy", bus.ll_ready_o, 0);
    next(); exp_wr(5'd21, 32'h210);
    to_neg(); chk("full_release", bus.ll_ready_o, 1);
    next(); idle(); exp_wr(5'd22, 32'h220);
    to_neg(); chk("full_last_addr", bus.rd_addr_o, 22);
    next(); idle();
    to_neg(); chk("full_drained", bus.rd_wr_o, 0);

    // forwarding from the pipeline write
    next(); wbp(5'd3, 32'h33); exp_wr(5'd3, 32'h33); dec(5'd3, 5'd3, 5'd8, 1'b1, 1'b0);
    to_neg(); chk("dual_fwd", bus.forward_decode_o, 0); chk("dual_stall", bus.stall_o, 1);
    next(); bus.wb_p_valid_i = 1'b0;
    to_neg(); chk("dual_after", bus.stall_o, 0);
    next(); idle(); wbp(5'd4, 32'h44); exp_wr(5'd4, 32'h44); dec(5'd1, 5'd4, 5'd8, 1'b1, 1'b0);
    to_neg(); chk("fwd_rs2", bus.forward_decode_o, 2'b10); chk("fwd_rs2_stall", bus.stall_o, 0);

    // x0 writes and pushes are ignored
    next(); idle(); wbp(5'd0, 32'hDEAD); ll(5'd0, 32'hBEEF); dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    to_neg();
    chk("x0_wr", bus.rd_wr_o, 0); chk("x0_stall", bus.stall_o, 0);
    chk("x0_fwd", bus.forward_decode_o, 0); chk("x0_ready", bus.ll_ready_o, 1);
    next(); idle();
    to_neg(); chk("x0_nopush", bus.rd_wr_o, 0);

    // reset mid-stream with two buffered entries and a pending register
    next(); wbp(5'd6, 32'h66); exp_wr(5'd6, 32'h66); ll(5'd25, 32'h250); dec(5'd0, 5'd0, 5'd15, 1'b1, 1'b1);
    to_neg();
    next(); idle(); wbp(5'd6, 32'h67); exp_wr(5'd6, 32'h67); ll(5'd26, 32'h260);
    to_neg(); chk("mr_pend_set", bus.ll_ready_o, 1);
    next(); idle(); dec(5'd15, 5'd0, 5'd0, 1'b0, 1'b0); rst_ni = 1'b0;
    to_neg();
    chk("mr_wr", bus.rd_wr_o, 0); chk("mr_addr", bus.rd_addr_o, 0); chk("mr_data", bus.rd_data_o, 0);
    chk("mr_ready", bus.ll_ready_o, 1); chk("mr_stall", bus.stall_o, 0); chk("mr_fwd", bus.forward_decode_o, 0);
    next(); rst_ni = 1'b1;
    to_neg(); chk("mr_post_wr", bus.rd_wr_o, 0); chk("mr_post_stall", bus.stall_o, 0);
    next(); idle();
    to_neg();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
